// File: rtl/and_gate_pkg.sv
// -----------------------------------------------------------------------------
// and_gate_pkg
// Shared definitions for the and_gate primitive and its registered stage.
//   DEF_WIDTH  : default operand/result width
//   DEF_CNT_W  : default width of the optional match counter
//   MAX_CNT_W  : widest counter the saturating-increment helper supports
//   and_flags_t: packed {all, any} reduction flags kept together in one register
//   sat_inc()  : saturating increment used by the optional match counter
// -----------------------------------------------------------------------------
package and_gate_pkg;

    localparam int unsigned DEF_WIDTH = 32'd1;
    localparam int unsigned DEF_CNT_W = 32'd16;

    // The helper works on a fixed wide container; callers zero-extend their
    // counter into it and truncate the result back, so CNT_W must not exceed this.
    localparam int unsigned MAX_CNT_W = 32'd64;

    // Reduction flags of the AND result, registered as one 2-bit word.
    typedef struct packed {
        logic all_v;   // every result bit is 1
        logic any_v;   // at least one result bit is 1
    } and_flags_t;

    // Saturating increment: returns cnt+1, or the all-ones value of a cnt_w-bit
    // counter once that value has been reached (never wraps).
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] cnt,
        input int unsigned          cnt_w
    );
        logic [MAX_CNT_W-1:0] max_v;
        if (cnt_w >= MAX_CNT_W) begin
            max_v = {MAX_CNT_W{1'b1}};
        end else begin
            max_v = (64'd1 << cnt_w) - 64'd1;
        end
        if (cnt >= max_v) begin
            return max_v;
        end else begin
            return cnt + 64'd1;
        end
    endfunction

endpackage

// File: rtl/and_gate_reg.sv
// -----------------------------------------------------------------------------
// and_gate_reg
// WIDTH-bit register with asynchronous active-low reset and an internal
// reset-release synchroniser.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears q_o immediately
//   d_i   : data to capture
//   q_o   : registered data
// After rst_n rises, the first rising edge only arms the register; the data is
// first captured on the second rising edge. This keeps every register of the
// block leaving reset on the same, deterministic edge.
// -----------------------------------------------------------------------------
module and_gate_reg #(
    parameter int unsigned WIDTH = 32'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic             ready_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Reset-release synchroniser: rises on the first clock edge after rst_n is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Next-state select: capture new data only once the register is armed.
    always_comb begin
        data_d = data_q;
        if (ready_q) begin
            data_d = d_i;
        end else begin
            data_d = data_q;
        end
    end

    // Data register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= {WIDTH{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/and_gate.sv
// -----------------------------------------------------------------------------
// and_gate
// Bitwise 2-input AND with a zero-latency combinational result, a registered
// copy, and registered all/any reduction flags.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (registered outputs clear at once)
//   a, b      : WIDTH-bit operands
//   y         : combinational a & b (independent of clk and rst_n)
//   y_q       : a & b registered, 1-cycle latency
//   all_q     : registered &(a & b)
//   any_q     : registered |(a & b)
//   match_cnt : CNT_W-bit saturating count of cycles where &(a & b) == 1,
//               present only when the macro AND_GATE_CNT_EN is defined
// Parameters: WIDTH >= 1, 1 <= CNT_W <= 64.
// -----------------------------------------------------------------------------
module and_gate
    import and_gate_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             all_q,
    output logic             any_q
`ifdef AND_GATE_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    logic [WIDTH-1:0] and_s;
    and_flags_t       flags_s;
    and_flags_t       flags_q;

    // Continuous assignment keeps plain Verilog & semantics, including X/Z propagation.
    assign and_s = a & b;
    assign y     = and_s;

    assign flags_s.all_v = &and_s;
    assign flags_s.any_v = |and_s;

    and_gate_reg #(
        .WIDTH (WIDTH)
    ) u_y_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (and_s),
        .q_o   (y_q)
    );

    and_gate_reg #(
        .WIDTH (32'd2)
    ) u_flags_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (flags_s),
        .q_o   (flags_q)
    );

    assign all_q = flags_q.all_v;
    assign any_q = flags_q.any_v;

`ifdef AND_GATE_CNT_EN
    logic             cnt_ready_q;
    logic [CNT_W-1:0] match_cnt_q;
    logic [CNT_W-1:0] match_cnt_d;

    // Counter arming flag: same release timing as the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ready_q <= 1'b0;
        end else begin
            cnt_ready_q <= 1'b1;
        end
    end

    // Saturating count of cycles where every result bit is 1.
    always_comb begin
        match_cnt_d = match_cnt_q;
        if (cnt_ready_q && flags_s.all_v) begin
            match_cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(match_cnt_q), CNT_W));
        end else begin
            match_cnt_d = match_cnt_q;
        end
    end

    // Match counter register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_q <= {CNT_W{1'b0}};
        end else begin
            match_cnt_q <= match_cnt_d;
        end
    end

    assign match_cnt = match_cnt_q;
`else
    // Counter width is meaningless without the counter; keep the parameter referenced.
    logic [CNT_W-1:0] unused_cnt_w_s;
    assign unused_cnt_w_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_and_gate.sv
module tb_and_gate;

    typedef struct {
        logic a;
        logic b;
        logic y;
    } comb_vec_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       all_v;
        logic       any_v;
        logic       a1;
        logic       b1;
        logic       y1;
    } w4_vec_t;

    logic       clk     = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst_n   = 1'b0;

    logic       a1, b1, y1, yq1, all1, any1;
    logic [3:0] a4, b4, y4, yq4;
    logic       all4, any4;
`ifdef AND_GATE_CNT_EN
    logic [1:0]  cnt1;
    logic [15:0] cnt4;
`endif

    int total = 0;
    int bad   = 0;

    comb_vec_t cv [4];
    w4_vec_t   wv [5];

    always #5 if (clk_run) clk = ~clk;

    and_gate #(.WIDTH(1), .CNT_W(2)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .y(y1), .y_q(yq1),
        .all_q(all1), .any_q(any1)
`ifdef AND_GATE_CNT_EN
        , .match_cnt(cnt1)
`endif
    );

    and_gate #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .y(y4), .y_q(yq4),
        .all_q(all4), .any_q(any4)
`ifdef AND_GATE_CNT_EN
        , .match_cnt(cnt4)
`endif
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] ai;
        logic [3:0] bi;
        cv[0] = '{1'b0, 1'b0, 1'b0};
        cv[1] = '{1'b0, 1'b1, 1'b0};
        cv[2] = '{1'b1, 1'b0, 1'b0};
        cv[3] = '{1'b1, 1'b1, 1'b1};
        wv[0] = '{4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        wv[1] = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        wv[2] = '{4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        wv[3] = '{4'b1111, 4'b0111, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        wv[4] = '{4'b0001, 4'b0011, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        #10;

        // Truth table, no clock running, held in reset.
        for (int i = 0; i < 4; i++) begin
            a1 = cv[i].a;
            b1 = cv[i].b;
            #10;
            chk("comb_y1", {15'd0, y1}, {15'd0, cv[i].y});
        end

        // Reset state with a=b=1.
        chk("rst_y1",   {15'd0, y1},   16'd1);
        chk("rst_yq1",  {15'd0, yq1},  16'd0);
        chk("rst_all1", {15'd0, all1}, 16'd0);
        chk("rst_any1", {15'd0, any1}, 16'd0);
        chk("rst_yq4",  {12'd0, yq4},  16'd0);

        // Exhaustive operand sweep on the 4-bit instance, combinational only.
        for (int i = 0; i < 256; i++) begin
            ai = i[7:4];
            bi = i[3:0];
            a4 = ai;
            b4 = bi;
            #1;
            chk("sweep_y4", {12'd0, y4}, {12'd0, ai & bi});
        end
        a4 = 4'h0; b4 = 4'h0;

        // Reset release: capture on the second rising edge.
        clk_run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_edge1_yq1",  {15'd0, yq1},  16'd0);
        chk("rel_edge1_all1", {15'd0, all1}, 16'd0);
        @(posedge clk); #1;
        chk("rel_edge2_yq1",  {15'd0, yq1},  16'd1);
        chk("rel_edge2_all1", {15'd0, all1}, 16'd1);
        chk("rel_edge2_any1", {15'd0, any1}, 16'd1);

        // Clocked vectors: 1-cycle latency, reductions, WIDTH=1 flag equality.
        prev = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a4 = wv[i].a; b4 = wv[i].b;
            a1 = wv[i].a1; b1 = wv[i].b1;
            #1;
            chk("w4_y_comb",  {12'd0, y4},  {12'd0, wv[i].y});
            chk("w4_yq_hold", {12'd0, yq4}, {12'd0, prev});
            @(posedge clk); #1;
            chk("w4_yq",   {12'd0, yq4},  {12'd0, wv[i].y});
            chk("w4_all",  {15'd0, all4}, {15'd0, wv[i].all_v});
            chk("w4_any",  {15'd0, any4}, {15'd0, wv[i].any_v});
            chk("w1_yq",   {15'd0, yq1},  {15'd0, wv[i].y1});
            chk("w1_all",  {15'd0, all1}, {15'd0, wv[i].y1});
            chk("w1_any",  {15'd0, any1}, {15'd0, wv[i].y1});
            prev = wv[i].y;
        end

        // Mid-operation reset between edges.
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF;
        @(posedge clk); #1;
        chk("mid_pre_yq4", {12'd0, yq4}, 16'h000F);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_yq4",  {12'd0, yq4},  16'd0);
        chk("mid_all4", {15'd0, all4}, 16'd0);
        chk("mid_any4", {15'd0, any4}, 16'd0);
        chk("mid_y4",   {12'd0, y4},   16'h000F);
        @(posedge clk); #1;
        chk("mid_held_yq4", {12'd0, yq4}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel1_yq4", {12'd0, yq4}, 16'd0);
        @(posedge clk); #1;
        chk("mid_rel2_yq4",  {12'd0, yq4},  16'h000F);
        chk("mid_rel2_all4", {15'd0, all4}, 16'd1);

`ifdef AND_GATE_CNT_EN
        begin
            logic [1:0] cexp [5];
            cexp[0] = 2'd1; cexp[1] = 2'd2; cexp[2] = 2'd3; cexp[3] = 2'd3; cexp[4] = 2'd3;
            @(negedge clk);
            a1 = 1'b0; b1 = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("cnt_rst", {14'd0, cnt1}, 16'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            a1 = 1'b1; b1 = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                chk("cnt_sat", {14'd0, cnt1}, {14'd0, cexp[k]});
            end
            @(negedge clk);
            a1 = 1'b0;
            @(posedge clk);
            @(posedge clk); #1;
            chk("cnt_hold", {14'd0, cnt1}, 16'd3);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
